vid_line_fetch: RTL and testbench

- Video-side consumer of the SDRAM controller's line-read interface.
- Generates per-line fetch requests (line index plus line-end strobe) and captures the returned 16-bit burst words into a double-buffered line RAM.
- Serialises the buffered words into 2-bit-per-pixel output for scanout: each word is {plane1 byte, plane0 byte}, MSB pixel first.
- Sits between the SDRAM controller and the video timing / DAC logic, all in one clock domain.

---
 rtl/orion_video_pkg.sv | 15 +
 rtl/vid_line_ram.sv | 26 ++
 rtl/vid_line_fetch.sv | 185 ++++++++++++++++++
 tb/tb_vid_line_fetch.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/orion_video_pkg.sv
// Shared defaults and scan-state encoding for the Orion video line fetch path.
package orion_video_pkg;

    localparam int VID_WORDS_PER_LINE = 128;
    localparam int VID_DISPLAY_WORDS  = 48;
    localparam int VID_LINES          = 256;
    localparam int VID_LINE_END_W     = 4;

    typedef enum logic [1:0] {
        SCAN_BLANK  = 2'd0,
        SCAN_LOAD   = 2'd1,
        SCAN_ACTIVE = 2'd2
    } scan_state_t;

endpackage

// File: rtl/vid_line_ram.sv
// Two-bank line buffer: one write port, one registered read port, address = {bank, ptr}.
module vid_line_ram
    import orion_video_pkg::*;
#(
    parameter int WORDS = VID_WORDS_PER_LINE,
    parameter int AW    = $clog2(2 * WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [15:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [15:0]   rdata
);

    logic [15:0] mem [2*WORDS];

    // Storage write and one-cycle registered read.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/vid_line_fetch.sv
// Requests SDRAM lines, captures bursts into a double-buffered line RAM and
// serialises each word {plane1, plane0} into 2-bit pixels, MSB first.
module vid_line_fetch
    import orion_video_pkg::*;
#(
    parameter int WORDS_PER_LINE = VID_WORDS_PER_LINE,
    parameter int DISPLAY_WORDS  = VID_DISPLAY_WORDS,
    parameter int LINES          = VID_LINES,
    parameter int LINE_END_W     = VID_LINE_END_W
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [15:0] i_vdata,
    input  logic        i_vdata_valid,
    input  logic        i_vdata_reset,
    output logic [7:0]  o_line_idx,
    output logic        o_line_end,
    input  logic        i_frame_start,
    input  logic        i_line_start,
    input  logic        i_pix_en,
    output logic [1:0]  o_pix,
    output logic        o_active,
    output logic        o_underrun,
    output logic        o_overrun
);

    localparam int PW = $clog2(WORDS_PER_LINE + 1);
    localparam int RW = $clog2(WORDS_PER_LINE);
    localparam int CW = $clog2(LINE_END_W + 1);

    logic          disp_bank, fill_bank;
    logic [PW-1:0] fill_ptr, fill_cnt;
    logic [7:0]    cur_line;
    logic [CW-1:0] end_cnt;
    scan_state_t   state;
    logic [RW-1:0] word_ptr;
    logic [2:0]    bit_cnt;
    logic [15:0]   sh, rd_data, cur_word_s;
    logic [8:0]    next_line_s;
    logic          line_go_s, req_s, wr_en_s;
    logic [7:0]    req_idx_s;

    vid_line_ram #(.WORDS(WORDS_PER_LINE), .AW(RW + 1)) u_ram (
        .clk   (i_clk),
        .we    (wr_en_s),
        .waddr ({fill_bank, fill_ptr[RW-1:0]}),
        .wdata (i_vdata),
        .raddr ({disp_bank, word_ptr}),
        .rdata (rd_data)
    );

    // Request selection, write qualification and the shifter source.
    always_comb begin
        next_line_s = {1'b0, cur_line} + 9'd1;
        line_go_s   = i_line_start & ~i_frame_start;
        req_s       = 1'b0;
        req_idx_s   = 8'd0;
        if (i_frame_start) begin
            req_s     = 1'b1;
            req_idx_s = 8'd0;
        end else if (line_go_s && (next_line_s < 9'(LINES))) begin
            req_s     = 1'b1;
            req_idx_s = next_line_s[7:0];
        end else begin
            req_s     = 1'b0;
            req_idx_s = 8'd0;
        end
        wr_en_s = i_vdata_valid & ~i_vdata_reset &
                  (fill_cnt < PW'(WORDS_PER_LINE)) & (fill_ptr < PW'(WORDS_PER_LINE));
        // At the start of every word the prefetched RAM output is the word to show.
        cur_word_s = (bit_cnt == 3'd0) ? rd_data : sh;
    end

    // Line request strobe, restarted by any new request.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_line_idx <= 8'd0;
            o_line_end <= 1'b0;
            end_cnt    <= CW'(0);
        end else if (req_s) begin
            o_line_idx <= req_idx_s;
            o_line_end <= 1'b1;
            end_cnt    <= CW'(LINE_END_W - 1);
        end else if (end_cnt != CW'(0)) begin
            end_cnt <= end_cnt - CW'(1);
        end else begin
            o_line_end <= 1'b0;
        end
    end

    // Fill pointer, bank swap, line counter and error flags.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            disp_bank  <= 1'b0;
            fill_bank  <= 1'b1;
            fill_ptr   <= PW'(0);
            fill_cnt   <= PW'(0);
            cur_line   <= 8'd0;
            o_underrun <= 1'b0;
            o_overrun  <= 1'b0;
        end else begin
            if (i_frame_start) begin
                cur_line <= 8'd0;
            end else if (line_go_s) begin
                disp_bank <= fill_bank;
                fill_bank <= disp_bank;
                if (fill_cnt < PW'(DISPLAY_WORDS)) begin
                    o_underrun <= 1'b1;
                end
                if (next_line_s < 9'(LINES)) begin
                    cur_line <= next_line_s[7:0];
                end
            end
            if (i_vdata_reset) begin
                fill_ptr <= PW'(0);
                fill_cnt <= PW'(0);
            end else begin
                if (wr_en_s) begin
                    fill_ptr <= fill_ptr + PW'(1);
                end
                if (line_go_s) begin
                    fill_cnt <= PW'(0);
                end else if (wr_en_s) begin
                    fill_cnt <= fill_cnt + PW'(1);
                end
            end
            if (i_vdata_valid && !i_vdata_reset && (fill_cnt == PW'(WORDS_PER_LINE))) begin
                o_overrun <= 1'b1;
            end
        end
    end

    // Scan FSM and pixel shifter.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state    <= SCAN_BLANK;
            o_active <= 1'b0;
            o_pix    <= 2'd0;
            word_ptr <= RW'(0);
            bit_cnt  <= 3'd0;
            sh       <= 16'd0;
        end else if (i_frame_start) begin
            state    <= SCAN_BLANK;
            o_active <= 1'b0;
            o_pix    <= 2'd0;
        end else if (i_line_start) begin
            state    <= SCAN_LOAD;
            o_active <= 1'b0;
            o_pix    <= 2'd0;
            word_ptr <= RW'(0);
            bit_cnt  <= 3'd0;
        end else begin
            case (state)
                SCAN_BLANK: begin
                    o_active <= 1'b0;
                    o_pix    <= 2'd0;
                end
                SCAN_LOAD: begin
                    state    <= SCAN_ACTIVE;
                    o_active <= 1'b1;
                end
                SCAN_ACTIVE: begin
                    if (i_pix_en) begin
                        o_pix   <= {cur_word_s[15], cur_word_s[7]};
                        sh      <= {cur_word_s[14:8], 1'b0, cur_word_s[6:0], 1'b0};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd0) begin
                            word_ptr <= word_ptr + RW'(1);
                        end
                        if ((bit_cnt == 3'd7) && (word_ptr == RW'(DISPLAY_WORDS))) begin
                            state    <= SCAN_BLANK;
                            o_active <= 1'b0;
                        end
                    end
                end
                default: begin
                    state    <= SCAN_BLANK;
                    o_active <= 1'b0;
                    o_pix    <= 2'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vid_line_fetch.sv
// Scoreboard bench for vid_line_fetch: line requests, fill flags and pixel stream.
module tb_vid_line_fetch;

    localparam int WPL = 128;
    localparam int DW  = 48;
    localparam int NL  = 4;
    localparam int LEW = 4;

    logic        clk = 1'b0;
    logic        i_reset;
    logic [15:0] i_vdata;
    logic        i_vdata_valid, i_vdata_reset;
    logic [7:0]  o_line_idx;
    logic        o_line_end;
    logic        i_frame_start, i_line_start, i_pix_en;
    logic [1:0]  o_pix;
    logic        o_active, o_underrun, o_overrun;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] wbuf [0:129];
    logic [1:0]  pix_q [$];
    logic [7:0]  req_q [$];

    always #5 clk = ~clk;

    vid_line_fetch #(
        .WORDS_PER_LINE (WPL),
        .DISPLAY_WORDS  (DW),
        .LINES          (NL),
        .LINE_END_W     (LEW)
    ) dut (
        .i_clk         (clk),
        .i_reset       (i_reset),
        .i_vdata       (i_vdata),
        .i_vdata_valid (i_vdata_valid),
        .i_vdata_reset (i_vdata_reset),
        .o_line_idx    (o_line_idx),
        .o_line_end    (o_line_end),
        .i_frame_start (i_frame_start),
        .i_line_start  (i_line_start),
        .i_pix_en      (i_pix_en),
        .o_pix         (o_pix),
        .o_active      (o_active),
        .o_underrun    (o_underrun),
        .o_overrun     (o_overrun)
    );

    task automatic pulse(input logic fs, input logic ls);
        i_frame_start = fs;
        i_line_start  = ls;
        @(negedge clk);
        i_frame_start = 1'b0;
        i_line_start  = 1'b0;
    endtask

    task automatic check_req();
        logic [7:0] exp_idx;
        exp_idx = (req_q.size() > 0) ? req_q.pop_front() : 8'hFF;
        for (int i = 0; i < LEW; i++) begin
            checks++;
            if (o_line_end !== 1'b1 || o_line_idx !== exp_idx) begin
                errors++;
                $display("FAIL line_req cycle %0d: end=%b idx=%0d, required end=1 idx=%0d",
                         i, o_line_end, o_line_idx, exp_idx);
            end
            @(negedge clk);
        end
        checks++;
        if (o_line_end !== 1'b0) begin
            errors++;
            $display("FAIL line_req_len: end=%b after %0d cycles, required 0", o_line_end, LEW);
        end
    endtask

    task automatic check_noreq(input int n);
        for (int i = 0; i < n; i++) begin
            checks++;
            if (o_line_end !== 1'b0) begin
                errors++;
                $display("FAIL no_req cycle %0d: end=%b idx=%0d, required end=0", i, o_line_end, o_line_idx);
            end
            @(negedge clk);
        end
    endtask

    task automatic gen_words(input logic [15:0] w0);
        for (int i = 0; i < 130; i++) wbuf[i] = 16'($urandom);
        wbuf[0] = w0;
    endtask

    task automatic fill(input int n);
        i_vdata_reset = 1'b1;
        repeat (3) @(negedge clk);
        i_vdata_reset = 1'b0;
        for (int i = 0; i < n; i++) begin
            i_vdata       = wbuf[i];
            i_vdata_valid = 1'b1;
            @(negedge clk);
        end
        i_vdata_valid = 1'b0;
    endtask

    task automatic push_line();
        for (int w = 0; w < DW; w++)
            for (int b = 7; b >= 0; b--)
                pix_q.push_back({wbuf[w][b+8], wbuf[w][b]});
    endtask

    task automatic display(input bit half);
        int         n = 0;
        int         cyc = 0;
        logic [1:0] exp_pix;
        checks++;
        if (o_active !== 1'b0) begin
            errors++;
            $display("FAIL active_load: o_active=%b, required 0", o_active);
        end
        @(negedge clk);
        checks++;
        if (o_active !== 1'b1) begin
            errors++;
            $display("FAIL active_rise: o_active=%b two cycles after line start, required 1", o_active);
        end
        while (n < DW * 8 && cyc < 2000) begin
            i_pix_en = half ? ((cyc % 2) == 0) : 1'b1;
            @(negedge clk);
            cyc++;
            if (i_pix_en) begin
                exp_pix = (pix_q.size() > 0) ? pix_q.pop_front() : 2'bxx;
                checks++;
                if (o_pix !== exp_pix) begin
                    errors++;
                    $display("FAIL pix %0d: o_pix=%0d, required %0d", n, o_pix, exp_pix);
                end
                n++;
                if (n < DW * 8) begin
                    checks++;
                    if (o_active !== 1'b1) begin
                        errors++;
                        $display("FAIL active_early_drop at pixel %0d: o_active=%b, required 1", n, o_active);
                    end
                end
            end
        end
        i_pix_en = 1'b0;
        checks++;
        if (o_active !== 1'b0 || n != DW * 8) begin
            errors++;
            $display("FAIL active_fall: o_active=%b after %0d pixels, required 0 after %0d", o_active, n, DW * 8);
        end
    endtask

    task automatic check_flags(input string tag, input logic und, input logic ovr);
        checks++;
        if (o_underrun !== und || o_overrun !== ovr) begin
            errors++;
            $display("FAIL flags_%s: underrun=%b overrun=%b, required underrun=%b overrun=%b",
                     tag, o_underrun, o_overrun, und, ovr);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (o_line_idx !== 8'd0 || o_line_end !== 1'b0 || o_pix !== 2'd0 ||
            o_active !== 1'b0 || o_underrun !== 1'b0 || o_overrun !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: idx=%0d end=%b pix=%0d act=%b und=%b ovr=%b, required all 0",
                     o_line_idx, o_line_end, o_pix, o_active, o_underrun, o_overrun);
        end
        i_reset = 1'b0;
        @(negedge clk);
        check_flags("after_reset", 1'b0, 1'b0);
    endtask

    task automatic test_frame_request();
        repeat (5) @(negedge clk);
        req_q.push_back(8'd0);
        pulse(1'b1, 1'b0);
        check_req();
        gen_words(16'hA5F0);
        fill(WPL);
        push_line();
        check_flags("full_fill", 1'b0, 1'b0);
    endtask

    task automatic test_pixel_order();
        req_q.push_back(8'd1);
        pulse(1'b0, 1'b1);
        fork
            check_req();
            display(1'b0);
        join
        check_flags("pixel_order", 1'b0, 1'b0);
    endtask

    task automatic test_underrun();
        gen_words(16'h0F0F);
        fill(20);
        req_q.push_back(8'd2);
        pulse(1'b0, 1'b1);
        check_req();
        check_flags("underrun", 1'b1, 1'b0);
        repeat (10) @(negedge clk);
        check_flags("underrun_sticky", 1'b1, 1'b0);
    endtask

    task automatic test_overrun_half_rate();
        gen_words(16'h3C96);
        wbuf[128] = 16'hFFFF;
        wbuf[129] = 16'h0000;
        fill(130);
        check_flags("overrun", 1'b1, 1'b1);
        push_line();
        req_q.push_back(8'd3);
        pulse(1'b0, 1'b1);
        fork
            check_req();
            display(1'b1);
        join
    endtask

    task automatic test_last_line();
        pulse(1'b0, 1'b1);
        check_noreq(8);
        req_q.push_back(8'd0);
        pulse(1'b1, 1'b1);
        check_req();
        checks++;
        if (o_active !== 1'b0 || o_pix !== 2'd0) begin
            errors++;
            $display("FAIL frame_wins: o_active=%b o_pix=%0d, required 0 0", o_active, o_pix);
        end
    endtask

    task automatic test_reset_midline();
        pulse(1'b0, 1'b1);
        @(negedge clk);
        i_pix_en = 1'b1;
        @(negedge clk);
        checks++;
        if (o_active !== 1'b1 || o_line_end !== 1'b1 || o_line_idx !== 8'd1) begin
            errors++;
            $display("FAIL midline_setup: act=%b end=%b idx=%0d, required 1 1 1", o_active, o_line_end, o_line_idx);
        end
        #2 i_reset = 1'b1;
        #1;
        checks++;
        if (o_active !== 1'b0 || o_pix !== 2'd0 || o_line_end !== 1'b0 || o_line_idx !== 8'd0 ||
            o_underrun !== 1'b0 || o_overrun !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: act=%b pix=%0d end=%b idx=%0d und=%b ovr=%b, required all 0",
                     o_active, o_pix, o_line_end, o_line_idx, o_underrun, o_overrun);
        end
        @(negedge clk);
        @(negedge clk);
        i_reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (o_active !== 1'b0) begin
                errors++;
                $display("FAIL post_reset_blank %0d: o_active=%b, required 0", i, o_active);
            end
        end
        i_pix_en = 1'b0;
        req_q.push_back(8'd0);
        pulse(1'b1, 1'b0);
        check_req();
        check_flags("post_reset", 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        i_reset       = 1'b1;
        i_vdata       = 16'd0;
        i_vdata_valid = 1'b0;
        i_vdata_reset = 1'b0;
        i_frame_start = 1'b0;
        i_line_start  = 1'b0;
        i_pix_en      = 1'b0;
        test_reset();
        test_frame_request();
        test_pixel_order();
        test_underrun();
        test_overrun_half_rate();
        test_last_line();
        test_reset_midline();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
